transpose_wr_burst_packer: RTL and testbench

//  Write-DMA stage downstream of the transpose output FIFO. Consumes the transposed beat stream
//  (valid/ready, DAT_W bits/beat) and packs it into MCIF write bursts at linearly increasing

---
 rtl/transpose_wr_burst_packer_if.sv | 30 +++
 rtl/transpose_wr_burst_packer.sv | 124 ++++++++++++
 tb/tb_transpose_wr_burst_packer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/transpose_wr_burst_packer_if.sv
// Handshake and bus bundle between the transpose beat stream, the MCIF write port and job control.
// The packer takes the slave view; whoever drives jobs and models MCIF takes the master view.
interface transpose_wr_burst_packer_if #(
  parameter int unsigned DAT_W      = 256,
  parameter int unsigned LOG2_BURST = 4
);
  localparam int unsigned PdW = 2 + LOG2_BURST + 32 + DAT_W;

  logic             start;
  logic [31:0]      base_addr;
  logic [31:0]      beat_num;
  logic             dat_in_vld;
  logic [DAT_W-1:0] dat_in_pd;
  logic             dat_in_rdy;
  logic             wr_req_vld;
  logic             wr_req_rdy;
  logic [PdW-1:0]   wr_req_pd;
  logic             wr_rsp_complete;
  logic             done;

  modport master (
    output start, base_addr, beat_num, dat_in_vld, dat_in_pd, wr_req_rdy, wr_rsp_complete,
    input  dat_in_rdy, wr_req_vld, wr_req_pd, done
  );

  modport slave (
    input  start, base_addr, beat_num, dat_in_vld, dat_in_pd, wr_req_rdy, wr_rsp_complete,
    output dat_in_rdy, wr_req_vld, wr_req_pd, done
  );
endinterface

// File: rtl/transpose_wr_burst_packer.sv
// Packs the transposed beat stream into MCIF write bursts at linearly increasing addresses,
// limits bursts in flight, and pulses done once every burst has completed.
module transpose_wr_burst_packer #(
  parameter int unsigned DAT_W      = 256,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned LOG2_BURST = 4,
  parameter int unsigned MAX_OUTS   = 8,
  parameter int unsigned LOG2_OUTS  = 3
) (
  input logic                        clk,
  input logic                        rst_n,
  transpose_wr_burst_packer_if.slave bus
);

  localparam logic [31:0]           Stride  = 32'(DAT_W / 8);
  localparam logic [LOG2_BURST-1:0] LenOne  = {{(LOG2_BURST-1){1'b0}}, 1'b1};
  localparam logic [LOG2_BURST-1:0] LenMax  = LOG2_BURST'(BURST_LEN - 1);
  localparam logic [LOG2_OUTS:0]    OutsOne = {{LOG2_OUTS{1'b0}}, 1'b1};
  localparam logic [LOG2_OUTS:0]    OutsMax = (LOG2_OUTS+1)'(MAX_OUTS);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           remain_q, remain_d;
  logic [LOG2_BURST-1:0] beat_idx_q, beat_idx_d;
  logic [LOG2_BURST-1:0] len_m1_q, len_m1_d;
  logic [LOG2_OUTS:0]    outs_cnt_q, outs_cnt_d;

  logic                  run, sof, eof, credit_ok, accept, inc, dec;
  logic [LOG2_BURST-1:0] first_len_m1, cur_len_m1;

  // Burst length is decided from the remaining count on the first beat, then held.
  assign first_len_m1 = (remain_q >= 32'(BURST_LEN)) ? LenMax
                                                      : remain_q[LOG2_BURST-1:0] - LenOne;
  assign sof          = (beat_idx_q == '0);
  assign cur_len_m1   = sof ? first_len_m1 : len_m1_q;
  assign eof          = (beat_idx_q == cur_len_m1);
  assign run          = (state_q == StRun);
  // Credit is only checked at burst start so a started burst always runs to completion.
  assign credit_ok    = !(sof && (outs_cnt_q == OutsMax));
  assign accept       = run && bus.dat_in_vld && bus.wr_req_rdy && credit_ok;
  assign inc          = accept && eof;
  assign dec          = bus.wr_rsp_complete && (outs_cnt_q != '0);

  assign bus.wr_req_vld = run && bus.dat_in_vld && credit_ok;
  assign bus.dat_in_rdy = run && bus.wr_req_rdy && credit_ok;
  assign bus.wr_req_pd  = {sof, eof, cur_len_m1, addr_q, bus.dat_in_pd};
  assign bus.done       = (state_q == StDone);

  always_comb begin
    outs_cnt_d = outs_cnt_q;
    if (inc && !dec) begin
      outs_cnt_d = outs_cnt_q + OutsOne;
    end else if (dec && !inc) begin
      outs_cnt_d = outs_cnt_q - OutsOne;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    beat_idx_d = beat_idx_q;
    len_m1_d   = len_m1_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          addr_d     = bus.base_addr;
          remain_d   = bus.beat_num;
          beat_idx_d = '0;
          state_d    = (bus.beat_num == 32'd0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (accept) begin
          remain_d = remain_q - 32'd1;
          if (sof) begin
            len_m1_d = first_len_m1;
          end
          if (eof) begin
            beat_idx_d = '0;
            addr_d     = addr_q + (32'(cur_len_m1) + 32'd1) * Stride;
          end else begin
            beat_idx_d = beat_idx_q + LenOne;
          end
          if (remain_q == 32'd1) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (outs_cnt_d == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      remain_q   <= '0;
      beat_idx_q <= '0;
      len_m1_q   <= '0;
      outs_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      beat_idx_q <= beat_idx_d;
      len_m1_q   <= len_m1_d;
      outs_cnt_q <= outs_cnt_d;
    end
  end

endmodule

// File: tb/tb_transpose_wr_burst_packer.sv
// Directed bench for transpose_wr_burst_packer: burst packing, credit limit, throttling and reset.
module tb_transpose_wr_burst_packer;

  localparam int unsigned DAT_W = 256;
  localparam int unsigned PD_W  = 2 + 4 + 32 + DAT_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  transpose_wr_burst_packer_if #(.DAT_W(DAT_W), .LOG2_BURST(4)) bus ();

  transpose_wr_burst_packer #(
    .DAT_W(DAT_W), .BURST_LEN(16), .LOG2_BURST(4), .MAX_OUTS(8), .LOG2_OUTS(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] job_base;
  logic [31:0] job_n;
  int          k;
  int          pend;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] req);
    n_vec++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DAT_W-1:0] pat(input int kk);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(kk);
    return {8{w}};
  endfunction

  // Expected {sof,eof,len_m1,addr,data} for beat kk of the current job.
  function automatic logic [PD_W-1:0] exp_pd(input int kk);
    int          b;
    int          off;
    logic [31:0] rem;
    logic [31:0] len;
    logic [3:0]  lm1;
    logic        s;
    logic        e;
    b   = kk / 16;
    off = kk % 16;
    rem = job_n - 32'(b * 16);
    len = (rem > 32'd16) ? 32'd16 : rem;
    lm1 = len[3:0] - 4'd1;
    s   = (off == 0);
    e   = (32'(off) == len - 32'd1);
    return {s, e, lm1, job_base + 32'(b) * 32'h200, pat(kk)};
  endfunction

  task automatic start_job(input logic [31:0] b, input logic [31:0] n);
    job_base      = b;
    job_n         = n;
    k             = 0;
    pend          = 0;
    bus.start     = 1'b1;
    bus.base_addr = b;
    bus.beat_num  = n;
    tick();
    bus.start     = 1'b0;
    bus.base_addr = '1;
    bus.beat_num  = '1;
  endtask

  task automatic beats(input int upto, input bit thr, input bit cmpl);
    int               cyc = 0;
    bit               v;
    bit               r;
    bit               c;
    bit               cr;
    logic [PD_W-1:0]  e;
    while (k < upto && cyc < 4000) begin
      v  = thr ? ($urandom_range(0, 3) != 0) : 1'b1;
      r  = thr ? ($urandom_range(0, 3) != 0) : 1'b1;
      c  = cmpl && (pend > 0) && ($urandom_range(0, 2) == 0);
      cr = !(((k % 16) == 0) && (pend == 8));
      bus.dat_in_vld      = v;
      bus.wr_req_rdy      = r;
      bus.dat_in_pd       = pat(k);
      bus.wr_rsp_complete = c;
      #1;
      chk("wr_req_vld", bus.wr_req_vld, v & cr);
      chk("dat_in_rdy", bus.dat_in_rdy, r & cr);
      if (v && r && cr) begin
        e = exp_pd(k);
        chk("wr_req_pd", bus.wr_req_pd, e);
        if (e[PD_W-2]) pend++;
        k++;
      end
      if (c) pend--;
      tick();
      cyc++;
    end
    bus.dat_in_vld      = 1'b0;
    bus.wr_rsp_complete = 1'b0;
    chk("beats_sent", k, upto);
  endtask

  task automatic drain();
    chk("done_pre", bus.done, 1'b0);
    while (pend > 0) begin
      bus.wr_rsp_complete = 1'b1;
      tick();
      bus.wr_rsp_complete = 1'b0;
      pend--;
      chk("done_after_cmpl", bus.done, pend == 0);
    end
    tick();
    chk("done_clr", bus.done, 1'b0);
  endtask

  initial begin
    bus.start           = 1'b0;
    bus.base_addr       = '0;
    bus.beat_num        = '0;
    bus.dat_in_vld      = 1'b1;
    bus.dat_in_pd       = '0;
    bus.wr_req_rdy      = 1'b1;
    bus.wr_rsp_complete = 1'b0;
    #12;
    chk("rst_vld", bus.wr_req_vld, 1'b0);
    chk("rst_rdy", bus.dat_in_rdy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("idle_rdy", bus.dat_in_rdy, 1'b0);
    bus.dat_in_vld = 1'b0;

    // 40 beats at 0x1000: bursts 0x1000/15, 0x1200/15, 0x1400/7; a stray start mid-job
    start_job(32'h1000, 32'd40);
    beats(20, 1'b0, 1'b0);
    bus.start     = 1'b1;
    bus.base_addr = 32'hDEAD_0000;
    bus.beat_num  = 32'd5;
    tick();
    bus.start = 1'b0;
    beats(40, 1'b0, 1'b0);
    drain();

    // single beat: sof=eof=1, len_m1 0
    start_job(32'h0000_0040, 32'd1);
    beats(1, 1'b0, 1'b0);
    drain();

    // zero beats: straight to done
    start_job(32'h3000, 32'd0);
    bus.dat_in_vld = 1'b1;
    bus.wr_req_rdy = 1'b1;
    #1;
    chk("zero_done", bus.done, 1'b1);
    chk("zero_vld", bus.wr_req_vld, 1'b0);
    tick();
    chk("zero_done_clr", bus.done, 1'b0);
    chk("zero_vld_idle", bus.wr_req_vld, 1'b0);
    bus.dat_in_vld = 1'b0;

    // credit limit: 8 bursts out, 9th sof blocked until a completion
    start_job(32'h0, 32'd160);
    beats(128, 1'b0, 1'b0);
    bus.dat_in_vld = 1'b1;
    bus.wr_req_rdy = 1'b1;
    bus.dat_in_pd  = pat(128);
    #1;
    chk("blk_rdy", bus.dat_in_rdy, 1'b0);
    chk("blk_vld", bus.wr_req_vld, 1'b0);
    tick();
    chk("blk_rdy_hold", bus.dat_in_rdy, 1'b0);
    bus.wr_rsp_complete = 1'b1;
    #1;
    chk("blk_rdy_cmpl", bus.dat_in_rdy, 1'b0);
    tick();
    bus.wr_rsp_complete = 1'b0;
    pend = 7;
    chk("rel_rdy", bus.dat_in_rdy, 1'b1);
    chk("rel_pd", bus.wr_req_pd, exp_pd(128));
    beats(143, 1'b0, 1'b0);
    // eof of 9th burst with a completion in the same cycle: count holds at 7
    bus.dat_in_vld      = 1'b1;
    bus.wr_req_rdy      = 1'b1;
    bus.dat_in_pd       = pat(143);
    bus.wr_rsp_complete = 1'b1;
    #1;
    chk("eof_cmpl_pd", bus.wr_req_pd, exp_pd(143));
    chk("eof_cmpl_rdy", bus.dat_in_rdy, 1'b1);
    tick();
    bus.wr_rsp_complete = 1'b0;
    k = 144;
    beats(160, 1'b0, 1'b0);
    drain();

    // random throttling with interleaved completions, address wrap past 2^32
    start_job(32'hFFFF_FF00, 32'd37);
    beats(37, 1'b1, 1'b1);
    drain();

    // reset mid-job with one burst outstanding, stray completion afterwards
    start_job(32'h8000, 32'd40);
    beats(18, 1'b0, 1'b0);
    bus.dat_in_vld = 1'b1;
    bus.wr_req_rdy = 1'b1;
    bus.dat_in_pd  = pat(18);
    #1;
    chk("pre_rst_vld", bus.wr_req_vld, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", bus.wr_req_vld, 1'b0);
    chk("mid_rst_rdy", bus.dat_in_rdy, 1'b0);
    chk("mid_rst_done", bus.done, 1'b0);
    bus.dat_in_vld = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.wr_rsp_complete = 1'b1;
    tick();
    bus.wr_rsp_complete = 1'b0;
    start_job(32'h0000_0100, 32'd3);
    beats(3, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
